// File: rtl/cache_bus_arbiter.sv
// Shared memory bus arbiter between the I-cache (F) and D-cache (M): grants
// BURST_LEN-beat bursts with zero added latency. Define ARB_ROUND_ROBIN_EN for round-robin priority.
module cache_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HRequestF,
    input  logic [ADDR_W-1:0] HAddrF,
    input  logic              HRequestM,
    input  logic              HWriteM,
    input  logic [ADDR_W-1:0] HAddrM,
    input  logic [DATA_W-1:0] HWDataM,
    output logic              BusReadyF,
    output logic              BusReadyM,
    output logic [DATA_W-1:0] HRData,
    output logic              MemReq,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, OWN_F, OWN_M} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat;
    logic          grant_m;
    logic          ack_ok;
    logic          burst_end;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         prio_m <= 1'b1;
        else if (burst_end) prio_m <= ~grant_m;
    end
`endif

    // In IDLE the grant is live so a beat can complete in the request's first cycle;
    // with nobody requesting the mux rests on the M side.
    always_comb begin
        grant_m = 1'b1;
        case (state)
            OWN_F:   grant_m = 1'b0;
            OWN_M:   grant_m = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            default: grant_m = HRequestF ? (HRequestM & prio_m) : 1'b1;
`else
            default: grant_m = HRequestF ? HRequestM : 1'b1;
`endif
        endcase
    end

    always_comb begin
        MemReq    = grant_m ? HRequestM : HRequestF;
        MemAddr   = grant_m ? HAddrM : HAddrF;
        MemWrite  = grant_m & HRequestM & HWriteM;
        MemWData  = HWDataM;
        HRData    = MemRData;
        ack_ok    = MemAck & MemReq;
        BusReadyM = ack_ok & grant_m;
        BusReadyF = ack_ok & ~grant_m;
        burst_end = ack_ok & (beat == LAST);
    end

    always_comb begin
        state_nxt = state;
        if (burst_end)
            state_nxt = IDLE;
        else if (state == IDLE && MemReq)
            state_nxt = grant_m ? OWN_M : OWN_F;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            if (ack_ok) beat <= burst_end ? '0 : beat + BW'(1);
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed + randomized bench for cache_bus_arbiter against a burst-level owner/beat-count model.
module tb_cache_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          HRequestF = 1'b0, HRequestM = 1'b0, HWriteM = 1'b0, MemAck = 1'b0;
    logic [AW-1:0] HAddrF = '0, HAddrM = '0;
    logic [DW-1:0] HWDataM = '0, MemRData = '0;
    logic          BusReadyF, BusReadyM, MemReq, MemWrite;
    logic [DW-1:0] HRData, MemWData;
    logic [AW-1:0] MemAddr;

    cache_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .HRequestF(HRequestF), .HAddrF(HAddrF),
        .HRequestM(HRequestM), .HWriteM(HWriteM), .HAddrM(HAddrM), .HWDataM(HWDataM),
        .BusReadyF(BusReadyF), .BusReadyM(BusReadyM), .HRData(HRData),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int errs = 0;

    // staged stimulus for the next cycle
    logic s_rf = 0, s_rm = 0, s_wm = 0, s_ack = 0;

    // reference model: who owns the bus, how many beats done, round-robin pointer
    int owner = 0;   // 0 none, 1 F, 2 M
    int beats = 0;
    bit ptr_m = 1'b1;
    bit rr_en;

    logic obs_rf, obs_rm, obs_req, obs_wr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input bit in_reset);
        bit m_wins, req, ack_eff;
        if (in_reset || owner == 0) begin
            if (HRequestM && HRequestF) m_wins = rr_en ? ptr_m : 1'b1;
            else                        m_wins = !HRequestF;
        end else begin
            m_wins = (owner == 2);
        end
        req     = m_wins ? HRequestM : HRequestF;
        ack_eff = MemAck && req;
        chk("MemReq",    MemReq,    req);
        chk("MemAddr",   MemAddr,   m_wins ? HAddrM : HAddrF);
        chk("MemWrite",  MemWrite,  m_wins && HRequestM && HWriteM);
        chk("MemWData",  MemWData,  HWDataM);
        chk("HRData",    HRData,    MemRData);
        chk("BusReadyM", BusReadyM, ack_eff && m_wins);
        chk("BusReadyF", BusReadyF, ack_eff && !m_wins);
        obs_rf = BusReadyF; obs_rm = BusReadyM; obs_req = MemReq; obs_wr = MemWrite;
        if (in_reset) return;
        if (ack_eff) begin
            beats++;
            if (beats == BL) begin
                beats = 0;
                owner = 0;
                ptr_m = !m_wins;
            end else begin
                owner = m_wins ? 2 : 1;
            end
        end else if (owner == 0 && req) begin
            owner = m_wins ? 2 : 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        HRequestF = s_rf; HRequestM = s_rm; HWriteM = s_wm; MemAck = s_ack;
        HAddrF = $urandom; HAddrM = $urandom; HWDataM = $urandom; MemRData = $urandom;
        #1 check_outputs(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        HRequestF = s_rf; HRequestM = s_rm; HWriteM = s_wm; MemAck = s_ack;
        #1;
        owner = 0; beats = 0; ptr_m = 1'b1;
        check_outputs(1'b1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int cnt;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        rr_en = 1'b1;
`else
        rr_en = 1'b0;
`endif
        // reset state with idle inputs
        #1 check_outputs(1'b1);
        chk("rst_MemReq", obs_req, 1'b0);
        chk("rst_MemWrite", obs_wr, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // lone D-cache read miss, zero-wait memory
        s_rm = 1; s_wm = 0; s_ack = 1;
        for (int i = 0; i < BL; i++) begin
            tick();
            chk("lone_m_rdyM", obs_rm, 1'b1);
            chk("lone_m_rdyF", obs_rf, 1'b0);
        end
        // idle again at cycle 4: F granted at once
        s_rm = 0; s_rf = 1;
        tick();
        chk("after_m_rdyF", obs_rf, 1'b1);
        for (int i = 1; i < BL; i++) tick();

        // simultaneous requests: M first (pointer back on M after the F burst), then F
        s_rm = 1; s_rf = 1; s_ack = 1;
        for (int i = 0; i < BL; i++) begin
            tick();
            chk("both_first_m", obs_rm, 1'b1);
        end
        s_rm = 0;
        for (int i = 0; i < BL; i++) begin
            tick();
            chk("both_then_f", obs_rf, 1'b1);
        end

        // writeback then refill with F also requesting
        s_rf = 1; s_rm = 1; s_ack = 1; s_wm = 1;
        for (int i = 0; i < BL; i++) begin
            tick();
            chk("wb_write", obs_wr, 1'b1);
        end
        s_wm = 0;
        for (int i = 0; i < 2 * BL; i++) tick();
        s_rf = 0; s_rm = 0;
        for (int i = 0; i < BL; i++) tick();

        // wait-state memory: ack every third cycle
        s_rm = 1; s_wm = 0; cnt = 0;
        for (int i = 0; i < 3 * BL; i++) begin
            s_ack = (i % 3 == 2);
            tick();
            if (obs_rm) cnt++;
        end
        chk("wait_strobes", cnt, BL);

        // reset after two beats of an F burst
        s_rm = 0; s_rf = 1; s_ack = 1;
        tick(); tick();
        s_rf = 0; s_ack = 0;
        do_reset();
        chk("midrst_MemReq", obs_req, 1'b0);
        s_rm = 1; s_ack = 1;
        tick();
        chk("post_rst_m", obs_rm, 1'b1);
        for (int i = 1; i < BL; i++) tick();

        // spurious ack with no request
        s_rm = 0; s_rf = 0; s_ack = 1;
        tick();
        chk("spur_rdyM", obs_rm, 1'b0);
        chk("spur_rdyF", obs_rf, 1'b0);
        // drop mid-burst then resume: 3 more beats still owed to M
        s_rm = 1; tick();
        s_rm = 0; s_rf = 1; tick();
        chk("drop_rdyF", obs_rf, 1'b0);
        s_rm = 1; s_rf = 0; cnt = 0;
        for (int i = 0; i < BL; i++) begin
            tick();
            if (obs_rm) cnt++;
        end
        chk("resume_beats", cnt, BL);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) s_rf = !s_rf;
            if ($urandom_range(0, 7) == 0) s_rm = !s_rm;
            s_wm  = $urandom_range(0, 1);
            s_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
